// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int BLK_AW = 6;
  localparam int BLK_DW = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Block storage for the data cache: valid/dirty/tag/data per block.
// Reads are asynchronous at the request index. Writes happen on the clock edge.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int BLOCKS = 8,
  parameter int IW     = 3,
  parameter int TW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TW-1:0]     rd_tag,
  output logic [BLK_DW-1:0] rd_data,
  input  logic              byte_we,
  input  logic [1:0]        byte_off,
  input  logic [7:0]        byte_data,
  input  logic              fill_we,
  input  logic [TW-1:0]     fill_tag,
  input  logic [BLK_DW-1:0] fill_data
);

  logic [BLOCKS-1:0] valid_q;
  logic [BLOCKS-1:0] dirty_q;
  logic [TW-1:0]     tag_mem  [BLOCKS];
  logic [BLK_DW-1:0] data_mem [BLOCKS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

  // Only the status bits are reset; tag and data are don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_data;
    end else if (byte_we) begin
      data_mem[index][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate byte cache in front of a block memory.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
//
// state     | meaning
// IDLE      | serve hits; a miss picks WRITEBACK (dirty victim) or FETCH
// WRITEBACK | write victim block to memory until MEM_BUSYWAIT drops
// FETCH     | read requested block from memory until MEM_BUSYWAIT drops
// UPDATE    | install fetched block as valid and clean
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int BLOCKS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [7:0]        ADDRESS,
  input  logic [7:0]        WRITEDATA,
  output logic [7:0]        READDATA,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [BLK_AW-1:0] MEM_ADDRESS,
  output logic [BLK_DW-1:0] MEM_WRITEDATA,
  input  logic [BLK_DW-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       HIT_COUNT,
  output logic [15:0]       MISS_COUNT
`endif
);

  localparam int IW = $clog2(BLOCKS);
  localparam int TW = BLK_AW - IW;

  state_t state, state_nxt;

  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_index;
  logic [1:0]        req_off;
  logic              req;
  logic              is_read;
  logic              hit;

  logic              rd_valid;
  logic              rd_dirty;
  logic [TW-1:0]     rd_tag;
  logic [BLK_DW-1:0] rd_data;

  logic              byte_we;
  logic              fill_we;
  logic [BLK_DW-1:0] fetch_buf;

  assign req_tag   = ADDRESS[7 -: TW];
  assign req_index = ADDRESS[2 +: IW];
  assign req_off   = ADDRESS[1:0];
  assign req       = READ | WRITE;
  assign is_read   = READ & ~WRITE;
  assign hit       = rd_valid && (rd_tag == req_tag);

  dcache_array #(
    .BLOCKS (BLOCKS),
    .IW     (IW),
    .TW     (TW)
  ) u_array (
    .clk       (CLK),
    .rst       (RESET),
    .index     (req_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .byte_we   (byte_we),
    .byte_off  (req_off),
    .byte_data (WRITEDATA),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_data (fetch_buf)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_buf <= '0;
    end else if (state == FETCH && !MEM_BUSYWAIT) begin
      fetch_buf <= MEM_READDATA;
    end
  end

  always_comb begin
    state_nxt     = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    byte_we       = 1'b0;
    fill_we       = 1'b0;
    BUSYWAIT      = req;
    READDATA      = '0;

    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_nxt = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
        end else if (req && hit) begin
          BUSYWAIT = 1'b0;
          byte_we  = WRITE;
          if (is_read) READDATA = rd_data[{req_off, 3'b000} +: 8];
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {rd_tag, req_index};
        MEM_WRITEDATA = rd_data;
        if (!MEM_BUSYWAIT) state_nxt = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {req_tag, req_index};
        if (!MEM_BUSYWAIT) state_nxt = UPDATE;
      end
      UPDATE: begin
        fill_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The CPU-facing outputs must read quiet while reset is held, even with a request pending.
    if (RESET) begin
      BUSYWAIT = 1'b0;
      READDATA = '0;
      byte_we  = 1'b0;
      fill_we  = 1'b0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        miss_pending;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  // A hit that merely completes a serviced miss is not counted as a hit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_pending <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      miss_pending <= 1'b1;
      if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end else if (state == IDLE && req && hit) begin
      if (miss_pending) begin
        miss_pending <= 1'b0;
      end else if (hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count;
  assign MISS_COUNT = miss_count;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: miss/fetch, hit, write-back, dual request, async reset.
module tb_dcache_controller;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT;
  logic [15:0] MISS_COUNT;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dcache_controller #(.BLOCKS(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET        = 1'b1;
    READ         = 1'b1;
    WRITE        = 1'b0;
    ADDRESS      = 8'h14;
    WRITEDATA    = 8'h00;
    MEM_READDATA = 32'h0;
    MEM_BUSYWAIT = 1'b1;
    #3;
    check("rst_busywait", BUSYWAIT, 0);
    check("rst_readdata", READDATA, 0);
    check("rst_mem_read", MEM_READ, 0);
    check("rst_mem_write", MEM_WRITE, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITEDATA, 0);
    READ = 1'b0;
    step();
    step();
    RESET = 1'b0;
    #1;
    check("idle_no_req_busy", BUSYWAIT, 0);

    // cold read miss on 0x14 -> fetch block 0x05
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    check("miss_busy", BUSYWAIT, 1);
    check("miss_no_mem_read_yet", MEM_READ, 0);
    step();
    check("fetch_mem_read", MEM_READ, 1);
    check("fetch_mem_write", MEM_WRITE, 0);
    check("fetch_addr", MEM_ADDRESS, 6'h05);
    check("fetch_busy", BUSYWAIT, 1);
    step();
    check("fetch_hold", MEM_READ, 1);
    MEM_READDATA = 32'hDDCCBBAA; MEM_BUSYWAIT = 1'b0;
    step();
    check("update_mem_read", MEM_READ, 0);
    check("update_busy", BUSYWAIT, 1);
    MEM_BUSYWAIT = 1'b1; MEM_READDATA = 32'h0;
    step();
    check("fill_busy", BUSYWAIT, 0);
    check("fill_readdata", READDATA, 8'hAA);

    // read hit on byte 1 of the same block
    step();
    ADDRESS = 8'h15;
    #1;
    check("hit_busy", BUSYWAIT, 0);
    check("hit_readdata", READDATA, 8'hBB);
    check("hit_no_mem_read", MEM_READ, 0);

    // write hit, then conflicting read forces write-back of the dirty block
    step();
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h14; WRITEDATA = 8'hAB;
    #1;
    check("wr_hit_busy", BUSYWAIT, 0);
    step();
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h34;
    #1;
    check("wb_miss_busy", BUSYWAIT, 1);
    step();
    check("wb_mem_write", MEM_WRITE, 1);
    check("wb_mem_read", MEM_READ, 0);
    check("wb_addr", MEM_ADDRESS, 6'h05);
    check("wb_wdata", MEM_WRITEDATA, 32'hDDCCBBAB);
    step();
    check("wb_hold", MEM_WRITE, 1);
    MEM_BUSYWAIT = 1'b0;
    step();
    check("wb_fetch_mem_write", MEM_WRITE, 0);
    check("wb_fetch_mem_read", MEM_READ, 1);
    check("wb_fetch_addr", MEM_ADDRESS, 6'h0D);
    MEM_READDATA = 32'h44332211;
    step();
    check("wb_update_mem_read", MEM_READ, 0);
    MEM_BUSYWAIT = 1'b1;
    step();
    check("wb_done_busy", BUSYWAIT, 0);
    check("wb_done_readdata", READDATA, 8'h11);
`ifdef DCACHE_STATS_EN
    check("stats_miss", MISS_COUNT, 2);
    check("stats_hit", HIT_COUNT, 2);
`endif

    // READ and WRITE together on a hit act as a write
    step();
    READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h35; WRITEDATA = 8'h5A;
    #1;
    check("rw_busy", BUSYWAIT, 0);
    check("rw_mem_read", MEM_READ, 0);
    check("rw_mem_write", MEM_WRITE, 0);
    step();
    WRITE = 1'b0;
    #1;
    check("rw_readback", READDATA, 8'h5A);
    check("rw_readback_busy", BUSYWAIT, 0);
    step();
    ADDRESS = 8'h15;
    #1;
    check("rw_dirty_miss_busy", BUSYWAIT, 1);
    MEM_BUSYWAIT = 1'b0;
    step();
    check("rw_wb_mem_write", MEM_WRITE, 1);
    check("rw_wb_addr", MEM_ADDRESS, 6'h0D);
    check("rw_wb_wdata", MEM_WRITEDATA, 32'h44335A11);
    step();
    MEM_BUSYWAIT = 1'b1;
    check("pre_rst_fetch", MEM_READ, 1);
    check("pre_rst_fetch_addr", MEM_ADDRESS, 6'h05);

    // async reset mid-fetch
    #2;
    RESET = 1'b1;
    #1;
    check("mid_rst_mem_read", MEM_READ, 0);
    check("mid_rst_busy", BUSYWAIT, 0);
    check("mid_rst_mem_addr", MEM_ADDRESS, 0);
    READ = 1'b0;
    #1;
    RESET = 1'b0;
    step();
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    check("post_rst_miss_busy", BUSYWAIT, 1);
    step();
    check("post_rst_fetch", MEM_READ, 1);
    check("post_rst_no_wb", MEM_WRITE, 0);
    check("post_rst_addr", MEM_ADDRESS, 6'h05);
    MEM_READDATA = 32'h000000C3; MEM_BUSYWAIT = 1'b0;
    step();
    step();
    check("post_rst_busy", BUSYWAIT, 0);
    check("post_rst_readdata", READDATA, 8'hC3);
    READ = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter BLOCKS, default 8, number of direct-mapped cache blocks (power of two, 2..32); index width IW = log2(BLOCKS), tag width TW = 6 - IW.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 READ  input  1  CPU byte-read request, held until BUSYWAIT low.
REQ-005 WRITE  input  1  CPU byte-write request, held until BUSYWAIT low.
REQ-006 ADDRESS  input  8  CPU byte address: [7:8-TW] tag, next IW bits index, [1:0] byte offset.
REQ-007 WRITEDATA  input  8  CPU write byte.
REQ-008 READDATA  output  8  CPU read byte.
REQ-009 BUSYWAIT  output  1  CPU stall.
REQ-010 MEM_READ  output  1  block read request to data memory.
REQ-011 MEM_WRITE  output  1  block write request to data memory.
REQ-012 MEM_ADDRESS  output  6  block address to data memory.
REQ-013 MEM_WRITEDATA  output  32  victim block to data memory, byte 0 in [7:0].
REQ-014 MEM_READDATA  input  32  fetched block from data memory, byte 0 in [7:0].
REQ-015 MEM_BUSYWAIT  input  1  data memory busy; request outputs held stable while high.

Function
REQ-016 Per block SHALL store valid, dirty, TW-bit tag, 32-bit data; write-back, write-allocate.
REQ-017 Hit = valid & tag match at ADDRESS index, evaluated combinationally.
REQ-018 Read hit: READDATA = selected byte and BUSYWAIT = 0 in the same cycle READ is presented; zero-cycle latency.
REQ-019 Write hit: BUSYWAIT = 0 same cycle; byte written and dirty set at next CLK edge.
REQ-020 READ and WRITE both high: treated as WRITE.
REQ-021 Miss: BUSYWAIT = 1 combinationally from the cycle the miss is seen until the request is serviced as a hit.
REQ-022 FSM states IDLE, WRITEBACK, FETCH, UPDATE.
REQ-023 IDLE -> WRITEBACK on miss with dirty victim; IDLE -> FETCH on miss with clean/invalid victim; otherwise stay.
REQ-024 WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {victim tag, index}, MEM_WRITEDATA = victim data; -> FETCH on edge where MEM_BUSYWAIT = 0.
REQ-025 FETCH: MEM_READ = 1, MEM_ADDRESS = {request tag, index}; -> UPDATE on edge where MEM_BUSYWAIT = 0, capturing MEM_READDATA.
REQ-026 UPDATE (one cycle): write block data, tag, valid = 1, dirty = 0; -> IDLE; request then completes as hit.
REQ-027 MEM_READ and MEM_WRITE never both high; both low in IDLE and UPDATE.
REQ-028 No request (READ = WRITE = 0): BUSYWAIT = 0, no state change.

Reset
REQ-029 RESET asserted (any time, including mid-WRITEBACK/FETCH) SHALL immediately force IDLE, clear all valid and dirty bits, drive MEM_READ = MEM_WRITE = 0, BUSYWAIT = 0, READDATA = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
REQ-030 Block data and tags need not be cleared by reset.

Configuration
REQ-031 Macro DCACHE_STATS_EN defined: extra outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], incremented once per completed-as-first-cycle hit and once per miss entry (IDLE exit), saturating at 16'hFFFF, cleared by RESET.
REQ-032 Macro undefined: no counters, no extra ports; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding and block-address width constant (6) and block-data width constant (32).
REQ-034 One sub-module dcache_array (valid/dirty/tag/data storage, async read, sync write) is natural; FSM and hit logic stay in dcache_controller.

Verification
REQ-035 Reset then READ addr 8'h14 -> BUSYWAIT 1, FETCH with MEM_ADDRESS 6'h05, after MEM_BUSYWAIT drop and UPDATE, READDATA = MEM_READDATA[7:0], BUSYWAIT 0.
REQ-036 Repeat READ 8'h15 -> hit, BUSYWAIT 0 same cycle, READDATA = fetched byte 1, no MEM_READ.
REQ-037 WRITE 8'hAB to 8'h14 (hit) then READ 8'h34 (same index, new tag) -> WRITEBACK with MEM_ADDRESS 6'h05, MEM_WRITEDATA[7:0] = 8'hAB, then FETCH 6'h0D.
REQ-038 RESET pulsed mid-FETCH -> MEM_READ falls asynchronously, FSM IDLE, subsequent READ 8'h14 misses.
REQ-039 READ and WRITE both high on hit -> write performed, dirty set, no memory traffic.
REQ-040 With DCACHE_STATS_EN: sequence REQ-035..037 -> MISS_COUNT 2, HIT_COUNT 2.
